c_step_sequencer: RTL and testbench

Control-step sequencer for multi-cycle instructions. It generates the step index `sel` and disable `dis` that drive the 3-to-8 control-step decoder, which turns them into one-hot step strobes. A run is launched by `start`, holds on `stall`, and can be cut short by `abort`. Each run lasts a programmable 1–8 steps and ends with a one-cycle `done` pulse to the instruction-fetch control.

---
 rtl/c_step_seq_pkg.sv | 20 ++
 rtl/c_step_counter.sv | 39 +++
 rtl/c_step_sequencer.sv | 117 +++++++++++
 tb/tb_c_step_sequencer.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/c_step_seq_pkg.sv
// ============================================================================
// Module   : c_step_seq_pkg
// Brief    : Shared encodings and constants for the control-step sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package c_step_seq_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int         SEL_W_DEFAULT = 3;
    localparam logic [2:0] STEP_LAST_MAX = 3'd7;

endpackage

`default_nettype wire

// File: rtl/c_step_counter.sv
// ============================================================================
// Module   : c_step_counter
// Brief    : Step counter with clear, load-zero, hold, increment and
//            terminal compare against the latched last-step index.
// Revision : 1.0
// ============================================================================
`default_nettype none

module c_step_counter #(
    parameter int SEL_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic             inc,
    input  logic [SEL_W-1:0] len_q,
    output logic [SEL_W-1:0] cnt,
    output logic             term
);

    logic [SEL_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= '0;
        end else if (inc) begin
            r_cnt <= r_cnt + SEL_W'(1);
        end
    end

    assign cnt  = r_cnt;
    assign term = (r_cnt == len_q);

endmodule

`default_nettype wire

// File: rtl/c_step_sequencer.sv
// ============================================================================
// Module   : c_step_sequencer
// Brief    : Control-step sequencer (start/stall/abort, 1..8 steps, done).
//            Optional back-to-back chaining: C_STEP_SEQ_CHAIN_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module c_step_sequencer
    import c_step_seq_pkg::*;
#(
    parameter int SEL_W = SEL_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [SEL_W-1:0] len,
    input  logic             stall,
    input  logic             abort,
    output logic [SEL_W-1:0] sel,
    output logic             dis,
    output logic             busy,
    output logic             done
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [SEL_W-1:0] r_len_q;
    logic [SEL_W-1:0] w_len_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic             w_clr;
    logic             w_load;
    logic             w_inc;
    logic             w_term;
    logic [SEL_W-1:0] w_cnt;

    c_step_counter #(
        .SEL_W (SEL_W)
    ) u_counter (
        .clk   (clk),
        .rst   (rst),
        .clr   (w_clr),
        .load  (w_load),
        .inc   (w_inc),
        .len_q (r_len_q),
        .cnt   (w_cnt),
        .term  (w_term)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_len_q <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_len_q <= w_len_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Priority: abort > stall > advance/start (rst handled in the registers).
    always_comb begin
        w_state_nxt = r_state;
        w_len_nxt   = r_len_q;
        w_done_nxt  = 1'b0;
        w_clr       = 1'b0;
        w_load      = 1'b0;
        w_inc       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start && !abort) begin
                    w_state_nxt = ST_RUN;
                    w_len_nxt   = len;
                    w_load      = 1'b1;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                    w_clr       = 1'b1;
                end else if (stall) begin
                    w_state_nxt = ST_RUN;
                end else if (w_term) begin
                    w_done_nxt = 1'b1;
`ifdef C_STEP_SEQ_CHAIN_EN
                    if (start) begin
                        w_len_nxt = len;
                        w_load    = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_clr       = 1'b1;
                    end
`else
                    w_state_nxt = ST_IDLE;
                    w_clr       = 1'b1;
`endif
                end else begin
                    w_inc = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_clr       = 1'b1;
            end
        endcase
    end

    assign sel  = w_cnt;
    assign busy = (r_state == ST_RUN);
    assign dis  = (r_state == ST_IDLE);
    assign done = r_done;

endmodule

`default_nettype wire

// File: tb/tb_c_step_sequencer.sv
// ============================================================================
// Module   : tb_c_step_sequencer
// Brief    : Self-checking bench: directed vector table plus random stimulus
//            against a behavioural model. Honours C_STEP_SEQ_CHAIN_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_c_step_sequencer;

    localparam logic [2:0] LMAX = c_step_seq_pkg::STEP_LAST_MAX;

    typedef struct {
        string      name;
        logic       rst;
        logic       start;
        logic       stall;
        logic       abort;
        logic [2:0] len;
        logic [2:0] e_sel;
        logic       e_dis;
        logic       e_done;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       stall = 1'b0;
    logic       abort = 1'b0;
    logic [2:0] len = 3'd0;
    logic [2:0] sel;
    logic       dis;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_pass   = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    c_step_sequencer #(.SEL_W(3)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .len   (len),
        .stall (stall),
        .abort (abort),
        .sel   (sel),
        .dis   (dis),
        .busy  (busy),
        .done  (done)
    );

    task automatic add(input string nm, input logic r, input logic s, input logic st,
                       input logic a, input logic [2:0] l, input logic [2:0] es,
                       input logic ed, input logic edn);
        vec_t v;
        v.name = nm; v.rst = r; v.start = s; v.stall = st; v.abort = a; v.len = l;
        v.e_sel = es; v.e_dis = ed; v.e_done = edn;
        tbl.push_back(v);
    endtask

    task automatic check(input string nm, input logic [2:0] es, input logic ed, input logic edn);
        n_checks++;
        if (sel === es && dis === ed && busy === ~ed && done === edn) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got sel=%0d dis=%0b busy=%0b done=%0b, expected sel=%0d dis=%0b busy=%0b done=%0b",
                     nm, sel, dis, busy, done, es, ed, ~ed, edn);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: run described as (active, step position, last step).
    bit m_active;
    int m_step;
    int m_last;
    bit m_done;

    task automatic model_edge(input bit r, input bit s, input bit st, input bit a, input int l);
        bit chain;
`ifdef C_STEP_SEQ_CHAIN_EN
        chain = 1'b1;
`else
        chain = 1'b0;
`endif
        m_done = 1'b0;
        if (r) begin
            m_active = 0; m_step = 0; m_last = 0;
        end else if (a) begin
            m_active = 0; m_step = 0;
        end else if (!m_active) begin
            if (s) begin
                m_active = 1; m_step = 0; m_last = l;
            end
        end else if (!st) begin
            if (m_step == m_last) begin
                m_done = 1'b1;
                if (chain && s) begin
                    m_step = 0; m_last = l;
                end else begin
                    m_active = 0; m_step = 0;
                end
            end else begin
                m_step = m_step + 1;
            end
        end
    endtask

    initial begin
        bit ch;
`ifdef C_STEP_SEQ_CHAIN_EN
        ch = 1'b1;
`else
        ch = 1'b0;
`endif
        //  name          rst st  stl ab  len  sel  dis done
        add("reset",      1, 0, 0, 0, 3'd0, 3'd0, 1, 0);
        add("idle",       0, 0, 0, 0, 3'd0, 3'd0, 1, 0);
        add("l3_s0",      0, 1, 0, 0, 3'd3, 3'd0, 0, 0);
        add("l3_s1",      0, 0, 0, 0, 3'd7, 3'd1, 0, 0);
        add("l3_s2",      0, 0, 0, 0, 3'd7, 3'd2, 0, 0);
        add("l3_s3",      0, 0, 0, 0, 3'd0, 3'd3, 0, 0);
        add("l3_done",    0, 0, 0, 0, 3'd0, 3'd0, 1, 1);
        add("l3_after",   0, 0, 0, 0, 3'd0, 3'd0, 1, 0);
        add("idle_st_ab", 0, 1, 0, 1, 3'd2, 3'd0, 1, 0);
        add("l0_s0",      0, 1, 0, 0, 3'd0, 3'd0, 0, 0);
        add("l0_done",    0, 0, 0, 0, 3'd0, 3'd0, 1, 1);
        add("l7_s0",      0, 1, 0, 0, LMAX, 3'd0, 0, 0);
        for (int i = 1; i <= 7; i++) add("l7_step", 0, 0, 0, 0, 3'd0, 3'(i), 0, 0);
        add("l7_done",    0, 0, 0, 0, 3'd0, 3'd0, 1, 1);
        add("ab_s0",      0, 1, 0, 0, LMAX, 3'd0, 0, 0);
        for (int i = 1; i <= 4; i++) add("ab_step", 0, 0, 0, 0, 3'd0, 3'(i), 0, 0);
        add("ab_abort",   0, 0, 0, 1, 3'd0, 3'd0, 1, 0);
        add("ab_after",   0, 0, 0, 0, 3'd0, 3'd0, 1, 0);
        add("stl_s0",     0, 1, 0, 0, 3'd5, 3'd0, 0, 0);
        add("stl_s1",     0, 0, 0, 0, 3'd0, 3'd1, 0, 0);
        add("stl_s2",     0, 0, 0, 0, 3'd0, 3'd2, 0, 0);
        add("stl_h2a",    0, 0, 1, 0, 3'd0, 3'd2, 0, 0);
        add("stl_h2b",    0, 0, 1, 0, 3'd0, 3'd2, 0, 0);
        add("stl_s3",     0, 0, 0, 0, 3'd0, 3'd3, 0, 0);
        add("stl_s4",     0, 0, 0, 0, 3'd0, 3'd4, 0, 0);
        add("stl_s5",     0, 0, 0, 0, 3'd0, 3'd5, 0, 0);
        add("stl_h5",     0, 0, 1, 0, 3'd0, 3'd5, 0, 0);
        add("stl_done",   0, 0, 0, 0, 3'd0, 3'd0, 1, 1);
        add("rst_s0",     0, 1, 0, 0, 3'd5, 3'd0, 0, 0);
        add("rst_s1",     0, 0, 0, 0, 3'd0, 3'd1, 0, 0);
        add("rst_s2",     0, 0, 0, 0, 3'd0, 3'd2, 0, 0);
        add("rst_s3",     0, 0, 0, 0, 3'd0, 3'd3, 0, 0);
        add("rst_mid",    1, 0, 0, 0, 3'd0, 3'd0, 1, 0);
        add("rst_after",  0, 0, 0, 0, 3'd0, 3'd0, 1, 0);
        add("ch_s0",      0, 1, 0, 0, 3'd2, 3'd0, 0, 0);
        add("ch_s1",      0, 0, 0, 0, 3'd0, 3'd1, 0, 0);
        add("ch_s2",      0, 0, 0, 0, 3'd0, 3'd2, 0, 0);
        add("ch_restart", 0, 1, 0, 0, 3'd2, 3'd0, !ch, 1);
        add("ch_n1",      0, 0, 0, 0, 3'd0, ch ? 3'd1 : 3'd0, !ch, 0);
        add("ch_n2",      0, 0, 0, 0, 3'd0, ch ? 3'd2 : 3'd0, !ch, 0);
        add("ch_end",     0, 0, 0, 0, 3'd0, 3'd0, 1, ch);

        #2;
        foreach (tbl[i]) begin
            rst = tbl[i].rst; start = tbl[i].start; stall = tbl[i].stall;
            abort = tbl[i].abort; len = tbl[i].len;
            tick();
            check(tbl[i].name, tbl[i].e_sel, tbl[i].e_dis, tbl[i].e_done);
        end

        // Randomised phase: model and DUT both start from a reset.
        m_active = 0; m_step = 0; m_last = 0; m_done = 0;
        for (int c = 0; c < 3000; c++) begin
            rst   = (c == 0) || ($urandom_range(0, 199) == 0);
            start = ($urandom_range(0, 99) < 35);
            stall = ($urandom_range(0, 99) < 25);
            abort = ($urandom_range(0, 99) < 4);
            len   = 3'($urandom_range(0, 7));
            model_edge(rst, start, stall, abort, int'(len));
            tick();
            check("random", 3'(m_step), !m_active, m_done);
        end

        rst = 0; start = 0; stall = 0; abort = 0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
